// File: rtl/four_bit_up_counter_if.sv
// Handshake bundle for the reference up-counter: the enable input and the
// count/terminal-count outputs.
interface four_bit_up_counter_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             tc;

  modport master (
    output enable,
    input  count,
    input  tc
  );

  modport slave (
    input  enable,
    output count,
    output tc
  );
endinterface

// File: rtl/four_bit_up_counter.sv
// Reference binary up-counter: register, +1 incrementer and hold/increment
// mux, with asynchronous active-low clear and combinational terminal count.
module four_bit_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  four_bit_up_counter_if.slave cnt
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] count_d;

  // Modulo-2**WIDTH increment; the carry out is dropped so all-ones wraps to zero.
  function automatic logic [WIDTH-1:0] incr(input logic [WIDTH-1:0] v);
    return v + ONE;
  endfunction

  always_comb begin
    count_inc = incr(count_q);
    count_d   = count_q;
    if (cnt.enable) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign cnt.count = count_q;
  // High in the cycle whose next enabled edge wraps the counter to zero.
  assign cnt.tc    = (count_q == ALL_ONES) & cnt.enable;

endmodule

// File: tb/tb_four_bit_up_counter.sv
// Directed bench for four_bit_up_counter, with a behavioural counter checked
// against the DUT on every clock in lockstep.
module tb_four_bit_up_counter;

  localparam int WIDTH = 4;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  bit   armed;
  logic [WIDTH-1:0] model_count;

  four_bit_up_counter_if #(.WIDTH(WIDTH)) cnt_if ();

  four_bit_up_counter #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .cnt   (cnt_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) model_count <= '0;
    else if (cnt_if.enable) model_count <= model_count + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (armed) begin
      check("lockstep_count", 32'(cnt_if.count), 32'(model_count));
      check("lockstep_tc", 32'(cnt_if.tc),
            32'((model_count == 4'd15) & cnt_if.enable));
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    reset    = 1'b1;
    cnt_if.enable = 1'b0;

    // Scenario 1: assert reset mid-cycle with clock running, enable high.
    tick();
    tick();
    cnt_if.enable = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_async_count", 32'(cnt_if.count), 32'd0);
    check("reset_async_tc", 32'(cnt_if.tc), 32'd0);
    armed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", 32'(cnt_if.count), 32'd0);
    end

    // Scenario 2: release with enable low.
    reset = 1'b1;
    cnt_if.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("release_hold_count", 32'(cnt_if.count), 32'd0);
      check("release_hold_tc", 32'(cnt_if.tc), 32'd0);
    end

    // Scenario 3: ten enabled edges.
    cnt_if.enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("count_up", 32'(cnt_if.count), 32'(i));
    end

    // Scenario 4: wrap-around through 15.
    tick(); check("to_11", 32'(cnt_if.count), 32'd11);
    tick(); check("to_12", 32'(cnt_if.count), 32'd12);
    tick(); check("to_13", 32'(cnt_if.count), 32'd13);
    tick(); check("to_14", 32'(cnt_if.count), 32'd14);
    check("tc_at_14", 32'(cnt_if.tc), 32'd0);
    tick(); check("to_15", 32'(cnt_if.count), 32'd15);
    check("tc_at_15", 32'(cnt_if.tc), 32'd1);
    cnt_if.enable = 1'b0;
    #1 check("tc_at_15_disabled", 32'(cnt_if.tc), 32'd0);
    cnt_if.enable = 1'b1;
    #1 check("tc_at_15_reenabled", 32'(cnt_if.tc), 32'd1);
    tick(); check("wrap_to_0", 32'(cnt_if.count), 32'd0);
    check("tc_after_wrap", 32'(cnt_if.tc), 32'd0);
    tick(); check("after_wrap_1", 32'(cnt_if.count), 32'd1);

    // Scenario 5: hold at 5 for four cycles, then resume.
    tick(); tick(); tick(); tick();
    check("reach_5", 32'(cnt_if.count), 32'd5);
    cnt_if.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_5", 32'(cnt_if.count), 32'd5);
    end
    cnt_if.enable = 1'b1;
    tick(); check("resume_6", 32'(cnt_if.count), 32'd6);

    // Scenario 6: 2 ns reset pulse between edges at count 9.
    tick(); tick(); tick();
    check("reach_9", 32'(cnt_if.count), 32'd9);
    #1 reset = 1'b0;
    #1 check("pulse_clear", 32'(cnt_if.count), 32'd0);
    #1 reset = 1'b1;
    tick(); check("restart_1", 32'(cnt_if.count), 32'd1);
    tick(); check("restart_2", 32'(cnt_if.count), 32'd2);
    tick(); check("restart_3", 32'(cnt_if.count), 32'd3);

    // Reset asserted on the same edge as an enabled increment.
    @(posedge clock);
    reset = 1'b0;
    #1 check("reset_wins", 32'(cnt_if.count), 32'd0);
    #2 reset = 1'b1;
    tick(); check("after_edge_reset_1", 32'(cnt_if.count), 32'd1);

    @(negedge clock);
    #1;
    armed = 1'b0;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
